// File: rtl/fp_mul_issue_arbiter.sv
// ---------------------------------------------------------------------------
// fp_mul_issue_arbiter
//
// Shares one externally instantiated floating-point multiply pipeline among
// NUM_REQ requesters. A round-robin arbiter issues at most one operation per
// cycle, the winner's id is queued as a tag, and when the pipeline returns a
// result the tag is popped and {id, product, flags} is written into an
// in-order result FIFO. Issue is credit-limited so the FIFO can always
// absorb every result already in the pipeline (the pipeline cannot stall).
//
// Ports
//   clk, rst        clock, asynchronous active-high reset (shared with pipeline)
//   req_valid       per-requester operation valid
//   req_ready       one-hot grant (transfer on req_valid[i] & req_ready[i])
//   req_in1/in2     packed operands, requester i at [32*i +: 32]
//   req_rm          packed rounding modes, requester i at [3*i +: 3]
//   mul_valid_in    registered issue strobe to the pipeline
//   mul_in1/in2/rm  registered operands to the pipeline
//   mul_out         product from the pipeline
//   mul_flags       {overflow, underflow, inexact, invalid} from the pipeline
//   mul_valid_out   result strobe from the pipeline
//   rsp_valid       result FIFO head valid
//   rsp_ready       consumer accepts the head
//   rsp_id          requester that issued the head result
//   rsp_data        head product (holds last value when the FIFO is empty)
//   rsp_flags       head flags
//   tag_error       sticky: pipeline produced a result with no tag queued
// ---------------------------------------------------------------------------
module fp_mul_issue_arbiter #(
  parameter  int NUM_REQ    = 4,
  parameter  int LATENCY    = 5,
  parameter  int FIFO_DEPTH = 8,
  localparam int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [32*NUM_REQ-1:0]  req_in1,
  input  logic [32*NUM_REQ-1:0]  req_in2,
  input  logic [3*NUM_REQ-1:0]   req_rm,
  output logic                   mul_valid_in,
  output logic [31:0]            mul_in1,
  output logic [31:0]            mul_in2,
  output logic [2:0]             mul_rm,
  input  logic [31:0]            mul_out,
  input  logic [3:0]             mul_flags,
  input  logic                   mul_valid_out,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [31:0]            rsp_data,
  output logic [3:0]             rsp_flags,
  output logic                   tag_error
);

  localparam int TQ_DEPTH = LATENCY + 1;
  localparam int TQ_PW    = (TQ_DEPTH > 1) ? $clog2(TQ_DEPTH) : 1;
  localparam int TQ_CW    = $clog2(TQ_DEPTH + 1);
  localparam int RF_PW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W    = $clog2(FIFO_DEPTH + 1);
  localparam int ENT_W    = ID_W + 36;

  // ---------------------------------------------------------------------
  // Operand unpacking
  // ---------------------------------------------------------------------
  logic [31:0] op_a  [NUM_REQ];
  logic [31:0] op_b  [NUM_REQ];
  logic [2:0]  op_rm [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign op_a[gi]  = req_in1[32*gi +: 32];
    assign op_b[gi]  = req_in2[32*gi +: 32];
    assign op_rm[gi] = req_rm[3*gi +: 3];
  end

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [ID_W-1:0]  rr_ptr_q,   rr_ptr_d;
  logic [CNT_W-1:0] in_flight_q, in_flight_d;
  logic             mul_valid_in_q;
  logic [31:0]      mul_in1_q, mul_in2_q;
  logic [2:0]       mul_rm_q;
  logic             tag_error_q;

  logic [ID_W-1:0]  tq_mem [TQ_DEPTH];
  logic [TQ_PW-1:0] tq_wr_q, tq_wr_d, tq_rd_q, tq_rd_d;
  logic [TQ_CW-1:0] tq_count_q, tq_count_d;

  logic [ENT_W-1:0] rf_mem [FIFO_DEPTH];
  logic [RF_PW-1:0] rf_wr_q, rf_wr_d, rf_rd_q, rf_rd_d;
  logic [CNT_W-1:0] rf_count_q, rf_count_d;

  logic             rsp_valid_q, rsp_valid_d;
  logic [ENT_W-1:0] rsp_ent_q, rsp_ent_d;

  // ---------------------------------------------------------------------
  // Credits and round-robin arbitration
  // ---------------------------------------------------------------------
  logic [CNT_W:0]  credit_used;
  logic            can_issue;
  logic            grant_valid;
  logic [ID_W-1:0] grant_id;

  assign credit_used = {1'b0, in_flight_q} + {1'b0, rf_count_q};
  assign can_issue   = credit_used < (CNT_W+1)'(FIFO_DEPTH);

  always_comb begin : arb
    int              idx_i;
    logic [ID_W-1:0] idx_v;
    grant_valid = 1'b0;
    grant_id    = '0;
    idx_i       = 0;
    idx_v       = '0;
    // Held off during reset so no transfer is reported while state is clearing.
    if (can_issue && !rst) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx_i = int'(rr_ptr_q) + k;
        if (idx_i >= NUM_REQ) idx_i = idx_i - NUM_REQ;
        idx_v = ID_W'(idx_i);
        if (!grant_valid && req_valid[idx_v]) begin
          grant_valid = 1'b1;
          grant_id    = idx_v;
        end
      end
    end
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
    assign req_ready[gi] = grant_valid && (grant_id == ID_W'(gi));
  end

  assign rr_ptr_d = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

  // ---------------------------------------------------------------------
  // Tag queue and in-flight count
  // ---------------------------------------------------------------------
  logic            tq_empty, tq_pop, tag_miss;
  logic [ID_W-1:0] tq_head;

  assign tq_empty = (tq_count_q == '0);
  assign tq_pop   = mul_valid_out && !tq_empty;
  assign tag_miss = mul_valid_out &&  tq_empty;
  assign tq_head  = tq_mem[tq_rd_q];

  function automatic logic [TQ_PW-1:0] tq_inc(input logic [TQ_PW-1:0] p);
    return (p == TQ_PW'(TQ_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [RF_PW-1:0] rf_inc(input logic [RF_PW-1:0] p);
    return (p == RF_PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    tq_wr_d     = grant_valid ? tq_inc(tq_wr_q) : tq_wr_q;
    tq_rd_d     = tq_pop ? tq_inc(tq_rd_q) : tq_rd_q;
    tq_count_d  = tq_count_q;
    in_flight_d = in_flight_q;
    case ({grant_valid, tq_pop})
      2'b10: begin
        tq_count_d  = tq_count_q + 1'b1;
        in_flight_d = in_flight_q + 1'b1;
      end
      2'b01: begin
        tq_count_d  = tq_count_q - 1'b1;
        in_flight_d = in_flight_q - 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (grant_valid) tq_mem[tq_wr_q] <= grant_id;
  end

  // ---------------------------------------------------------------------
  // Result FIFO with a registered head
  // ---------------------------------------------------------------------
  logic             rf_push, rf_pop, rf_bypass;
  logic [ENT_W-1:0] rf_push_ent;

  assign rf_push     = tq_pop;
  assign rf_pop      = rsp_valid_q && rsp_ready;
  assign rf_push_ent = {tq_head, mul_out, mul_flags};
  // The incoming entry becomes the next head when nothing else remains after the pop.
  assign rf_bypass   = rf_push && (rf_count_q == (rf_pop ? CNT_W'(1) : CNT_W'(0)));

  always_comb begin
    rf_wr_d    = rf_push ? rf_inc(rf_wr_q) : rf_wr_q;
    rf_rd_d    = rf_pop  ? rf_inc(rf_rd_q) : rf_rd_q;
    rf_count_d = rf_count_q;
    case ({rf_push, rf_pop})
      2'b10:   rf_count_d = rf_count_q + 1'b1;
      2'b01:   rf_count_d = rf_count_q - 1'b1;
      default: ;
    endcase
    rsp_valid_d = (rf_count_d != '0);
    rsp_ent_d   = rsp_ent_q;
    if (rsp_valid_d) rsp_ent_d = rf_bypass ? rf_push_ent : rf_mem[rf_rd_d];
  end

  always_ff @(posedge clk) begin
    if (rf_push) rf_mem[rf_wr_q] <= rf_push_ent;
  end

  // ---------------------------------------------------------------------
  // Registered state
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q       <= '0;
      in_flight_q    <= '0;
      mul_valid_in_q <= 1'b0;
      mul_in1_q      <= '0;
      mul_in2_q      <= '0;
      mul_rm_q       <= '0;
      tag_error_q    <= 1'b0;
      tq_wr_q        <= '0;
      tq_rd_q        <= '0;
      tq_count_q     <= '0;
      rf_wr_q        <= '0;
      rf_rd_q        <= '0;
      rf_count_q     <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_ent_q      <= '0;
    end else begin
      mul_valid_in_q <= grant_valid;
      if (grant_valid) begin
        mul_in1_q <= op_a[grant_id];
        mul_in2_q <= op_b[grant_id];
        mul_rm_q  <= op_rm[grant_id];
        rr_ptr_q  <= rr_ptr_d;
      end
      in_flight_q <= in_flight_d;
      tag_error_q <= tag_error_q | tag_miss;
      tq_wr_q     <= tq_wr_d;
      tq_rd_q     <= tq_rd_d;
      tq_count_q  <= tq_count_d;
      rf_wr_q     <= rf_wr_d;
      rf_rd_q     <= rf_rd_d;
      rf_count_q  <= rf_count_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_ent_q   <= rsp_ent_d;
    end
  end

  assign mul_valid_in = mul_valid_in_q;
  assign mul_in1      = mul_in1_q;
  assign mul_in2      = mul_in2_q;
  assign mul_rm       = mul_rm_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_id       = rsp_ent_q[ENT_W-1 -: ID_W];
  assign rsp_data     = rsp_ent_q[35:4];
  assign rsp_flags    = rsp_ent_q[3:0];
  assign tag_error    = tag_error_q;

endmodule

// File: tb/tb_fp_mul_issue_arbiter.sv
// ---------------------------------------------------------------------------
// Self-checking bench for fp_mul_issue_arbiter. A small behavioural stand-in
// for the multiply pipeline (LATENCY-deep shift register) returns exact
// products for the operand pairs used here: 1.0*x = x, 2.0*3.0 = 6.0 and
// inf*0 = qNaN with the invalid flag.
// ---------------------------------------------------------------------------
module tb_fp_mul_issue_arbiter;

  localparam int NUM_REQ = 4;
  localparam int LAT     = 5;
  localparam int DEPTH   = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [127:0] req_in1, req_in2;
  logic [11:0]  req_rm;
  logic         mul_valid_in;
  logic [31:0]  mul_in1, mul_in2;
  logic [2:0]   mul_rm;
  logic [31:0]  mul_out;
  logic [3:0]   mul_flags;
  logic         mul_valid_out;
  logic         rsp_valid, rsp_ready;
  logic [1:0]   rsp_id;
  logic [31:0]  rsp_data;
  logic [3:0]   rsp_flags;
  logic         tag_error;
  logic         force_vout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fp_mul_issue_arbiter #(.NUM_REQ(NUM_REQ), .LATENCY(LAT), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_in1(req_in1), .req_in2(req_in2), .req_rm(req_rm),
    .mul_valid_in(mul_valid_in), .mul_in1(mul_in1), .mul_in2(mul_in2), .mul_rm(mul_rm),
    .mul_out(mul_out), .mul_flags(mul_flags), .mul_valid_out(mul_valid_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_flags(rsp_flags), .tag_error(tag_error)
  );

  // ---------------- pipeline stand-in ----------------
  function automatic logic [35:0] fmul_ref(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h3F800000)                       return {b, 4'b0000};
    if (a == 32'h40000000 && b == 32'h40400000)  return {32'h40C00000, 4'b0000};
    if (a == 32'h7F800000 && b == 32'h00000000)  return {32'h7FC00000, 4'b0001};
    return {32'hDEADBEEF, 4'b0000};
  endfunction

  logic [LAT-1:0] pv;
  logic [31:0]    pd [LAT];
  logic [3:0]     pf [LAT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pv <= '0;
    else     pv <= {pv[LAT-2:0], mul_valid_in};
  end

  always_ff @(posedge clk) begin
    {pd[0], pf[0]} <= fmul_ref(mul_in1, mul_in2);
    for (int s = 1; s < LAT; s++) begin
      pd[s] <= pd[s-1];
      pf[s] <= pf[s-1];
    end
  end

  assign mul_valid_out = pv[LAT-1] | force_vout;
  assign mul_out       = pd[LAT-1];
  assign mul_flags     = pf[LAT-1];

  // ---------------- helpers ----------------
  function automatic logic [31:0] op_val(input int i);
    return 32'h41000000 + 32'(i) * 32'h00100000;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    req_valid  = '0;
    rsp_ready  = 1'b0;
    force_vout = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic set_identity_ops();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_in1[32*i +: 32] = 32'h3F800000;
      req_in2[32*i +: 32] = op_val(i);
      req_rm[3*i +: 3]    = 3'b000;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst        = 1'b1;
    force_vout = 1'b0;
    rsp_ready  = 1'b0;
    req_valid  = 4'hF;
    set_identity_ops();
    tick();
    tick();
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready: got %h expected %h", req_ready, 4'b0000); end
    checks++; if (mul_valid_in !== 1'b0) begin errors++; $display("FAIL reset_mul_valid_in: got %b expected 0", mul_valid_in); end
    checks++; if (mul_in1 !== 32'h0 || mul_in2 !== 32'h0 || mul_rm !== 3'b0) begin errors++; $display("FAIL reset_mul_ops: got %h %h %h expected 0 0 0", mul_in1, mul_in2, mul_rm); end
    checks++; if (rsp_valid !== 1'b0 || rsp_id !== 2'd0) begin errors++; $display("FAIL reset_rsp_valid_id: got %b %0d expected 0 0", rsp_valid, rsp_id); end
    checks++; if (rsp_data !== 32'h0 || rsp_flags !== 4'h0) begin errors++; $display("FAIL reset_rsp_data: got %h %h expected 0 0", rsp_data, rsp_flags); end
    checks++; if (tag_error !== 1'b0) begin errors++; $display("FAIL reset_tag_error: got %b expected 0", tag_error); end
    req_valid = '0;
    rst       = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_single_op();
    logic early;
    do_reset();
    req_in1[31:0] = 32'h40000000;
    req_in2[31:0] = 32'h40400000;
    req_rm[2:0]   = 3'b000;
    req_valid     = 4'b0001;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_grant: got %b expected 0001", req_ready); end
    tick();  // acceptance edge
    req_valid = '0;
    checks++; if (mul_valid_in !== 1'b1 || mul_in1 !== 32'h40000000 || mul_in2 !== 32'h40400000 || mul_rm !== 3'b000) begin
      errors++; $display("FAIL single_issue: got v=%b %h %h %h expected v=1 40000000 40400000 0", mul_valid_in, mul_in1, mul_in2, mul_rm);
    end
    tick();
    checks++; if (mul_valid_in !== 1'b0 || mul_in1 !== 32'h40000000) begin errors++; $display("FAIL single_issue_hold: got v=%b %h expected v=0 40000000", mul_valid_in, mul_in1); end
    early = 1'b0;
    repeat (4) begin
      tick();
      if (rsp_valid) early = 1'b1;
    end
    checks++; if (early !== 1'b0) begin errors++; $display("FAIL single_early_rsp: got %b expected 0", early); end
    tick();
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0) begin errors++; $display("FAIL single_rsp_valid: got v=%b id=%0d expected v=1 id=0", rsp_valid, rsp_id); end
    checks++; if (rsp_data !== 32'h40C00000 || rsp_flags !== 4'h0) begin errors++; $display("FAIL single_rsp_data: got %h %h expected 40c00000 0", rsp_data, rsp_flags); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checks++; if (rsp_valid !== 1'b0 || rsp_data !== 32'h40C00000) begin errors++; $display("FAIL single_empty_hold: got v=%b %h expected v=0 40c00000", rsp_valid, rsp_data); end
    $display("test_single_op done");
  endtask

  task automatic test_back_to_back();
    int   exp_q[$];
    int   got;
    int   e;
    logic [3:0] exp_rdy;
    do_reset();
    set_identity_ops();
    got       = 0;
    rsp_ready = 1'b1;
    req_valid = 4'hF;
    for (int c = 0; c < 12; c++) begin
      #1;
      exp_rdy = 4'b0001 << (c % 4);
      checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL b2b_grant[%0d]: got %b expected %b", c, req_ready, exp_rdy); end
      if (rsp_valid) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL b2b_unexpected_rsp: got id %0d expected none", rsp_id); end
        else begin
          e = exp_q.pop_front();
          got++;
          if (rsp_id !== 2'(e) || rsp_data !== op_val(e)) begin errors++; $display("FAIL b2b_rsp: got id=%0d %h expected id=%0d %h", rsp_id, rsp_data, e, op_val(e)); end
        end
      end
      exp_q.push_back(c % 4);
      tick();
    end
    req_valid = '0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (rsp_valid) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL b2b_unexpected_rsp: got id %0d expected none", rsp_id); end
        else begin
          e = exp_q.pop_front();
          got++;
          if (rsp_id !== 2'(e) || rsp_data !== op_val(e)) begin errors++; $display("FAIL b2b_rsp: got id=%0d %h expected id=%0d %h", rsp_id, rsp_data, e, op_val(e)); end
        end
      end
      tick();
    end
    checks++; if (got != 12) begin errors++; $display("FAIL b2b_count: got %0d expected 12", got); end
    $display("test_back_to_back done");
  endtask

  task automatic test_backpressure();
    int exp_q[$];
    int grants;
    int got;
    int last_id;
    int e;
    do_reset();
    set_identity_ops();
    rsp_ready = 1'b0;
    req_valid = 4'hF;
    grants    = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) begin grants++; exp_q.push_back(i); end
      tick();
    end
    #1;
    checks++; if (grants != 8) begin errors++; $display("FAIL bp_issue_count: got %0d expected 8", grants); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_stalled: got %b expected 0000", req_ready); end
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== op_val(0)) begin
      errors++; $display("FAIL bp_head: got v=%b id=%0d %h expected v=1 id=0 %h", rsp_valid, rsp_id, rsp_data, op_val(0));
    end
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    grants    = 0;
    last_id   = -1;
    for (int c = 0; c < 20; c++) begin
      #1;
      for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) begin grants++; last_id = i; exp_q.push_back(i); end
      tick();
    end
    checks++; if (grants != 1) begin errors++; $display("FAIL bp_one_more_grant: got %0d expected 1", grants); end
    checks++; if (last_id != 0) begin errors++; $display("FAIL bp_refill_id: got %0d expected 0", last_id); end
    req_valid = '0;
    rsp_ready = 1'b1;
    got       = 0;
    for (int c = 0; c < 30; c++) begin
      #1;
      if (rsp_valid) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL bp_unexpected_rsp: got id %0d expected none", rsp_id); end
        else begin
          e = exp_q.pop_front();
          got++;
          if (rsp_id !== 2'(e) || rsp_data !== op_val(e)) begin errors++; $display("FAIL bp_drain: got id=%0d %h expected id=%0d %h", rsp_id, rsp_data, e, op_val(e)); end
        end
      end
      tick();
    end
    checks++; if (got != 8) begin errors++; $display("FAIL bp_drain_count: got %0d expected 8", got); end
    rsp_ready = 1'b0;
    $display("test_backpressure done");
  endtask

  task automatic test_flags();
    bit seen;
    do_reset();
    req_in1[64 +: 32] = 32'h7F800000;
    req_in2[64 +: 32] = 32'h00000000;
    req_rm[6 +: 3]    = 3'b000;
    req_valid         = 4'b0100;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL flags_grant: got %b expected 0100", req_ready); end
    tick();
    req_valid = '0;
    seen      = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      tick();
      if (rsp_valid) seen = 1'b1;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL flags_timeout: got no rsp_valid expected rsp_valid=1"); end
    else if (rsp_data !== 32'h7FC00000 || rsp_flags !== 4'b0001 || rsp_id !== 2'd2) begin
      errors++; $display("FAIL flags_rsp: got %h %b id=%0d expected 7fc00000 0001 id=2", rsp_data, rsp_flags, rsp_id);
    end
    $display("test_flags done");
  endtask

  task automatic test_tag_error();
    do_reset();
    force_vout = 1'b1;
    tick();
    force_vout = 1'b0;
    checks++; if (tag_error !== 1'b1) begin errors++; $display("FAIL tag_error_set: got %b expected 1", tag_error); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL tag_error_no_push: got %b expected 0", rsp_valid); end
    repeat (3) tick();
    checks++; if (tag_error !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL tag_error_sticky: got %b v=%b expected 1 v=0", tag_error, rsp_valid); end
    $display("test_tag_error done");
  endtask

  task automatic test_reset_mid_burst();
    bit seen;
    set_identity_ops();
    rsp_ready = 1'b0;
    req_valid = 4'hF;
    repeat (4) tick();
    checks++; if (mul_valid_in !== 1'b1 || mul_in1 !== 32'h3F800000) begin errors++; $display("FAIL midrst_busy: got v=%b %h expected v=1 3f800000", mul_valid_in, mul_in1); end
    rst = 1'b1;
    tick();
    checks++; if (req_ready !== 4'b0 || mul_valid_in !== 1'b0 || mul_in1 !== 32'h0 || mul_in2 !== 32'h0 || mul_rm !== 3'b0) begin
      errors++; $display("FAIL midrst_issue: got rdy=%b v=%b %h %h %h expected all 0", req_ready, mul_valid_in, mul_in1, mul_in2, mul_rm);
    end
    checks++; if (rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_data !== 32'h0 || rsp_flags !== 4'h0 || tag_error !== 1'b0) begin
      errors++; $display("FAIL midrst_rsp: got v=%b id=%0d %h %h te=%b expected all 0", rsp_valid, rsp_id, rsp_data, rsp_flags, tag_error);
    end
    req_valid = '0;
    rst       = 1'b0;
    seen      = 1'b0;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (rsp_valid) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midrst_discard: got rsp_valid seen=%b expected 0", seen); end
    $display("test_reset_mid_burst done");
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = '0;
    req_in1    = '0;
    req_in2    = '0;
    req_rm     = '0;
    rsp_ready  = 1'b0;
    force_vout = 1'b0;
    test_reset();
    test_single_op();
    test_back_to_back();
    test_backpressure();
    test_flags();
    test_tag_error();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
